// File: rtl/line_fetch_arbiter.sv
// Framebuffer port arbiter: the display line fetch (priority) and a pixel writer share one BRAM port.
// Optional macro LINE_DOUBLE_EN: one fetch per pair of display lines (row = next >> 1).
module line_fetch_arbiter #(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int TOTAL_H_PIXELS  = 1650,
  parameter int ACTIVE_LINES    = 720,
  parameter int TOTAL_LINES     = 750,
  parameter int WORDS_PER_LINE  = 40,
  parameter int ADDR_WIDTH      = 15,
  parameter int DATA_WIDTH      = 32,
  parameter int READ_LATENCY    = 2
) (
  input  logic                                pixel_clk_in,
  input  logic                                rst_n_in,
  input  logic [$clog2(TOTAL_H_PIXELS)-1:0]   hcount_in,
  input  logic [$clog2(TOTAL_LINES)-1:0]      vcount_in,
  input  logic                                wr_req_in,
  input  logic [ADDR_WIDTH-1:0]               wr_addr_in,
  input  logic [DATA_WIDTH-1:0]               wr_data_in,
  output logic                                wr_gnt_out,
  output logic [ADDR_WIDTH-1:0]               mem_addr_out,
  output logic                                mem_we_out,
  output logic [DATA_WIDTH-1:0]               mem_wdata_out,
  input  logic [DATA_WIDTH-1:0]               mem_rdata_in,
  output logic                                lb_we_out,
  output logic [$clog2(WORDS_PER_LINE)-1:0]   lb_addr_out,
  output logic [DATA_WIDTH-1:0]               lb_data_out,
  output logic                                lb_wr_bank_out,
  output logic                                lb_rd_bank_out,
  output logic                                fetch_busy_out,
  output logic                                overrun_out,
  output logic [1:0]                          state_dbg_out
);

  localparam int HCW = $clog2(TOTAL_H_PIXELS);
  localparam int VCW = $clog2(TOTAL_LINES);
  localparam int LBW = $clog2(WORDS_PER_LINE);
  localparam int DCW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                state_q;
  logic [LBW-1:0]        word_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] acc_q;
  logic                  synced_q;
  logic [DCW-1:0]        drain_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_we_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  rd_issue_q;
  logic [READ_LATENCY-1:0] lb_vld_q;
  logic [LBW-1:0]        lb_idx_q [READ_LATENCY];
  logic                  rd_bank_q;
  logic                  overrun_q;

  logic [VCW-1:0]        next_row;
  logic                  trig;
  logic                  in_range;
  logic                  parity_ok;
  logic                  row_zero;
  logic                  fetch_trig;
  logic                  start_fetch;
  logic [ADDR_WIDTH-1:0] base_d;
  logic [LBW-1:0]        word_d;

  assign next_row  = (vcount_in == VCW'(TOTAL_LINES - 1)) ? '0 : vcount_in + VCW'(1);
  assign trig      = (hcount_in == HCW'(ACTIVE_H_PIXELS));
  assign in_range  = (next_row < VCW'(ACTIVE_LINES));
  assign row_zero  = (next_row == '0);
`ifdef LINE_DOUBLE_EN
  assign parity_ok = ~next_row[0];
`else
  assign parity_ok = 1'b1;
`endif
  // Before the first row-0 trigger the accumulator is meaningless, so every fetch is held off.
  assign fetch_trig  = trig && in_range && parity_ok && (synced_q || row_zero);
  assign start_fetch = fetch_trig && (state_q == S_IDLE);
  assign base_d      = row_zero ? '0 : acc_q;
  assign word_d      = word_q + LBW'(1);

  // Writer handshake: the writer holds req/addr/data until a cycle with wr_req_in && wr_gnt_out;
  // that cycle is the transfer and the write appears on the memory port one cycle later.
  assign wr_gnt_out = wr_req_in && (state_q == S_IDLE || state_q == S_DRAIN) && !fetch_trig;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      base_q      <= '0;
      acc_q       <= '0;
      synced_q    <= 1'b0;
      drain_q     <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rd_issue_q  <= 1'b0;
      lb_vld_q    <= '0;
      for (int k = 0; k < READ_LATENCY; k++) lb_idx_q[k] <= '0;
      rd_bank_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      mem_we_q   <= 1'b0;
      rd_issue_q <= 1'b0;

      // Read-data tracking: each issued read lands in the line buffer READ_LATENCY cycles later.
      lb_vld_q[0] <= rd_issue_q;
      lb_idx_q[0] <= word_q;
      for (int k = 1; k < READ_LATENCY; k++) begin
        lb_vld_q[k] <= lb_vld_q[k-1];
        lb_idx_q[k] <= lb_idx_q[k-1];
      end

      if (fetch_trig && row_zero) synced_q <= 1'b1;
      if (fetch_trig && state_q != S_IDLE) overrun_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (start_fetch) begin
            state_q    <= S_FETCH;
            base_q     <= base_d;
            acc_q      <= base_d + ADDR_WIDTH'(WORDS_PER_LINE);
            word_q     <= '0;
            mem_addr_q <= base_d;
            rd_issue_q <= 1'b1;
          end else if (wr_gnt_out) begin
            mem_addr_q  <= wr_addr_in;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= wr_data_in;
          end
        end
        S_FETCH: begin
          if (word_q == LBW'(WORDS_PER_LINE - 1)) begin
            state_q <= S_DRAIN;
            drain_q <= '0;
          end else begin
            word_q     <= word_d;
            mem_addr_q <= base_q + ADDR_WIDTH'(word_d);
            rd_issue_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (wr_gnt_out) begin
            mem_addr_q  <= wr_addr_in;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= wr_data_in;
          end
          if (drain_q == DCW'(READ_LATENCY - 1)) begin
            state_q   <= S_IDLE;
            rd_bank_q <= ~rd_bank_q;
          end else begin
            drain_q <= drain_q + DCW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_addr_out   = mem_addr_q;
  assign mem_we_out     = mem_we_q;
  assign mem_wdata_out  = mem_wdata_q;
  assign lb_we_out      = lb_vld_q[READ_LATENCY-1];
  assign lb_addr_out    = lb_idx_q[READ_LATENCY-1];
  assign lb_data_out    = mem_rdata_in;
  assign lb_rd_bank_out = rd_bank_q;
  assign lb_wr_bank_out = ~rd_bank_q;
  assign fetch_busy_out = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign overrun_out    = overrun_q;
  assign state_dbg_out  = state_q;

endmodule

// File: tb/tb_line_fetch_arbiter.sv
// Bench for line_fetch_arbiter: compressed video timing, random pixel writes, BRAM model and a
// timeline-based reference (fetch window offsets from the trigger cycle).
module tb_line_fetch_arbiter;

  localparam int ACTIVE_H = 1280;
  localparam int TOTAL_H  = 1650;
  localparam int ACTIVE_V = 720;
  localparam int TOTAL_V  = 750;
  localparam int WPL      = 40;
  localparam int AW       = 15;
  localparam int DW       = 32;
  localparam int RL       = 2;
  localparam int HCW      = $clog2(TOTAL_H);
  localparam int VCW      = $clog2(TOTAL_V);
  localparam int LBW      = $clog2(WPL);
  localparam int FAR      = 1000000;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [HCW-1:0] hcount;
  logic [VCW-1:0] vcount;
  logic           wr_req;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic           wr_gnt;
  logic [AW-1:0]  mem_addr;
  logic           mem_we;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata;
  logic           lb_we;
  logic [LBW-1:0] lb_addr;
  logic [DW-1:0]  lb_data;
  logic           lb_wr_bank;
  logic           lb_rd_bank;
  logic           fetch_busy;
  logic           overrun;
  logic [1:0]     state_dbg;

  line_fetch_arbiter #(
    .ACTIVE_H_PIXELS(ACTIVE_H), .TOTAL_H_PIXELS(TOTAL_H), .ACTIVE_LINES(ACTIVE_V),
    .TOTAL_LINES(TOTAL_V), .WORDS_PER_LINE(WPL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .READ_LATENCY(RL)
  ) dut (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
    .wr_req_in(wr_req), .wr_addr_in(wr_addr), .wr_data_in(wr_data), .wr_gnt_out(wr_gnt),
    .mem_addr_out(mem_addr), .mem_we_out(mem_we), .mem_wdata_out(mem_wdata),
    .mem_rdata_in(mem_rdata), .lb_we_out(lb_we), .lb_addr_out(lb_addr), .lb_data_out(lb_data),
    .lb_wr_bank_out(lb_wr_bank), .lb_rd_bank_out(lb_rd_bank), .fetch_busy_out(fetch_busy),
    .overrun_out(overrun), .state_dbg_out(state_dbg)
  );

  // framebuffer BRAM model, two-cycle read latency
  logic [DW-1:0] fb [0:(1<<AW)-1];
  bit            seen [0:(1<<AW)-1];
  logic [DW-1:0] rd_p1, rd_p2;

  function automatic logic [DW-1:0] init_word(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [DW-1:0] fb_word(input int a);
    return seen[a] ? fb[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      fb[mem_addr]   <= mem_wdata;
      seen[mem_addr] <= 1'b1;
    end
    rd_p1 <= seen[mem_addr] ? fb[mem_addr] : init_word(int'(mem_addr));
    rd_p2 <= rd_p1;
  end
  assign mem_rdata = rd_p2;

  // scoreboard / reference state
  int n_checks, n_pass, cyc, t_fetch, base_m, acc_m, last_addr_m;
  bit synced_m, bank_m, overrun_m, wr_due, pend, rand_en;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pdata;
  logic [AW+DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    synced_m = 0; bank_m = 0; overrun_m = 0; wr_due = 0; pend = 0;
    t_fetch = -1; base_m = 0; acc_m = 0; last_addr_m = 0;
    exp_q.delete();
  endtask

  // Async reset pulse; outputs are checked while reset is held.
  task automatic do_reset();
    #1;
    rst_n = 1'b0; wr_req = 1'b0; hcount = '0; vcount = '0;
    @(posedge clk); #1;
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_lb_we", lb_we, 0);
    check("rst_lb_addr", lb_addr, 0);
    check("rst_rd_bank", lb_rd_bank, 0);
    check("rst_wr_bank", lb_wr_bank, 1);
    check("rst_busy", fetch_busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_gnt", wr_gnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One pixel clock with the given timing position; all outputs checked on the falling edge.
  task automatic tick(input int h, input int v);
    int k, nxt, ea;
    bit vtrig, in_fetch;
    logic [AW+DW-1:0] tr;
    @(posedge clk); #1;
    hcount = HCW'(h);
    vcount = VCW'(v);
    if (!pend && rand_en && $urandom_range(0, 7) == 0) begin
      pend = 1; paddr = AW'($urandom); pdata = $urandom;
    end
    wr_req = pend; wr_addr = paddr; wr_data = pdata;
    @(negedge clk);
    cyc++;
    k = (t_fetch >= 0) ? cyc - t_fetch : FAR;
    in_fetch = (k >= 1 && k <= WPL);
    if (k == WPL + RL + 1) bank_m = ~bank_m;

    if (wr_due) begin
      tr = exp_q.pop_front();
      check("wr_mem_we", mem_we, 1);
      check("wr_mem_addr", mem_addr, tr[AW+DW-1:DW]);
      check("wr_mem_wdata", mem_wdata, tr[DW-1:0]);
      last_addr_m = int'(tr[AW+DW-1:DW]);
    end else if (in_fetch) begin
      ea = base_m + k - 1;
      check("rd_mem_we", mem_we, 0);
      check("rd_mem_addr", mem_addr, ea);
      last_addr_m = ea;
    end else begin
      check("idle_mem_we", mem_we, 0);
      check("idle_mem_addr", mem_addr, last_addr_m);
    end
    wr_due = 0;

    check("busy", fetch_busy, (k >= 1 && k <= WPL + RL));
    check("lb_we", lb_we, (k >= RL + 1 && k <= WPL + RL));
    if (k >= RL + 1 && k <= WPL + RL) begin
      check("lb_addr", lb_addr, k - RL - 1);
      check("lb_data", lb_data, fb_word(base_m + k - RL - 1));
    end
    check("rd_bank", lb_rd_bank, bank_m);
    check("wr_bank", lb_wr_bank, !bank_m);
    check("overrun", overrun, overrun_m);

    nxt = (v == TOTAL_V - 1) ? 0 : v + 1;
    vtrig = (h == ACTIVE_H) && (nxt < ACTIVE_V) && (synced_m || nxt == 0);
`ifdef LINE_DOUBLE_EN
    vtrig = vtrig && (nxt % 2 == 0);
`endif
    check("wr_gnt", wr_gnt, pend && !in_fetch && !vtrig);
    if (pend && wr_gnt) begin
      exp_q.push_back({paddr, pdata});
      wr_due = 1;
      pend = 0;
    end
    if (vtrig) begin
      if (nxt == 0) synced_m = 1;
      if (k >= 1 && k <= WPL + RL) overrun_m = 1;
      else begin
        base_m = (nxt == 0) ? 0 : acc_m;
        acc_m = base_m + WPL;
        t_fetch = cyc;
      end
    end
  endtask

  // driver: a compressed line around the blanking trigger, with the directed writer cases
  task automatic run_line(input int v, input int h_lo, input int h_hi);
    rand_en = !(v >= 3 && v <= 6);
    for (int h = h_lo; h <= h_hi; h++) begin
      if (v == 5 && h == ACTIVE_H + 1 && !pend) begin
        pend = 1; paddr = AW'(16'h1234); pdata = 32'hDEADBEEF;
      end
      if (v == 6 && h == ACTIVE_H && !pend) begin
        pend = 1; paddr = AW'($urandom); pdata = $urandom;
      end
      tick(h, v);
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0;
    paddr = '0; pdata = '0; rand_en = 1;
    rst_n = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0; hcount = '0; vcount = '0;
    model_reset();
    do_reset();

    // full frame, entered a few lines before the row-0 trigger
    for (int v = 745; v < TOTAL_V; v++) run_line(v, 1278, 1326);
    for (int v = 0; v < TOTAL_V; v++) run_line(v, 1278, 1326);
    for (int v = 0; v < 3; v++) run_line(v, 1278, 1326);

    // reset in the middle of a fetch at line 300: nothing until the row-0 trigger
    run_line(298, 1278, 1326);
    run_line(299, 1278, 1326);
    run_line(300, 1278, 1300);
    do_reset();
    run_line(300, 1301, 1326);
    for (int v = 301; v < TOTAL_V; v++) run_line(v, 1278, 1326);
    for (int v = 0; v < 3; v++) run_line(v, 1278, 1326);

    // second trigger while still fetching: flagged and ignored
    run_line(3, 1278, 1290);
    tick(ACTIVE_H, 3);
    run_line(3, 1281, 1340);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/line_fetch_arbiter.md
Name: line_fetch_arbiter

Overview:
- Owns the single framebuffer memory port and shares it between two users.
- User 1 is the display line fetcher. During horizontal blanking it copies the next visible row from the framebuffer into a double-banked line buffer.
- User 2 is a generic pixel writer (drawing/text engine) using a req/gnt handshake.
- Sits between the video timing generator (hcount/vcount inputs) and the framebuffer BRAM.
- Display fetch always has priority over writes.

Parameters:
- ACTIVE_H_PIXELS, 1280, visible pixels per line.
- TOTAL_H_PIXELS, 1650, total pixels per line including blanking.
- ACTIVE_LINES, 720, visible lines per frame.
- TOTAL_LINES, 750, total lines per frame.
- WORDS_PER_LINE, 40, framebuffer words per displayed row. Must satisfy WORDS_PER_LINE+READ_LATENCY < TOTAL_H_PIXELS-ACTIVE_H_PIXELS.
- ADDR_WIDTH, 15, framebuffer word address width.
- DATA_WIDTH, 32, framebuffer word width.
- READ_LATENCY, 2, cycles from mem_addr_out to valid mem_rdata_in.

Ports:
- pixel_clk_in  in  1  pixel clock.
- rst_n_in  in  1  asynchronous active-low reset.
- hcount_in  in  $clog2(TOTAL_H_PIXELS)  horizontal count from timing generator.
- vcount_in  in  $clog2(TOTAL_LINES)  vertical count from timing generator.
- wr_req_in  in  1  writer request; held with addr/data until granted.
- wr_addr_in  in  ADDR_WIDTH  writer word address.
- wr_data_in  in  DATA_WIDTH  writer word data.
- wr_gnt_out  out  1  writer grant; transfer occurs on a cycle with wr_req_in && wr_gnt_out.
- mem_addr_out  out  ADDR_WIDTH  framebuffer address (registered).
- mem_we_out  out  1  framebuffer write enable (registered).
- mem_wdata_out  out  DATA_WIDTH  framebuffer write data (registered).
- mem_rdata_in  in  DATA_WIDTH  framebuffer read data.
- lb_we_out  out  1  line buffer write strobe.
- lb_addr_out  out  $clog2(WORDS_PER_LINE)  line buffer word index.
- lb_data_out  out  DATA_WIDTH  line buffer write data (mem_rdata_in pass-through).
- lb_wr_bank_out  out  1  bank being filled.
- lb_rd_bank_out  out  1  bank display reads; lb_wr_bank_out = ~lb_rd_bank_out.
- fetch_busy_out  out  1  high in FETCH or DRAIN.
- overrun_out  out  1  sticky error flag.

Behaviour:
- Reset (async, rst_n_in low): state IDLE, all outputs 0. Includes lb_rd_bank_out=0 (so lb_wr_bank_out=1), overrun_out=0, base address=0, synced=0.
- Trigger cycle: hcount_in==ACTIVE_H_PIXELS.
  - next row = (vcount_in==TOTAL_LINES-1) ? 0 : vcount_in+1.
  - A fetch starts only if next<ACTIVE_LINES and (synced or next==0).
- Base address:
  - Set to 0 when next==0, which also sets synced=1.
  - Otherwise incremented by WORDS_PER_LINE per fetch, using an accumulator (no multiplier).
  - After reset mid-frame, all fetches are suppressed until the first row-0 trigger.
- States:
  - IDLE: writes may be granted. On a valid trigger go to FETCH, word index i=0.
  - FETCH: one read per cycle; mem_addr_out=base+i, mem_we_out=0, for i=0..WORDS_PER_LINE-1. After the last issue go to DRAIN.
  - DRAIN: wait READ_LATENCY cycles for in-flight data. Writes may be granted. On exit, toggle lb_rd_bank_out and return to IDLE.
- Line buffer writes: lb_we_out=1 exactly READ_LATENCY cycles after each read address is on mem_addr_out, with lb_addr_out=i. Tracked by a READ_LATENCY-deep valid/index shift register.
- Write grant:
  - wr_gnt_out = wr_req_in && state∈{IDLE,DRAIN} && not a valid trigger cycle. Combinational.
  - Cycle after a transfer: mem_addr_out=wr_addr_in, mem_we_out=1, mem_wdata_out=wr_data_in.
  - One write per cycle maximum.
- Conflicts:
  - Trigger and wr_req_in in the same cycle: the fetch wins and the writer waits.
  - A request arriving during FETCH is held off, with no loss, until DRAIN.
- Idle port: with no fetch and no grant, mem_we_out=0 and mem_addr_out holds its last value.
- Overrun: a valid trigger while not IDLE sets overrun_out=1 and is ignored. overrun_out clears only on reset.

Optional Feature:
- LINE_DOUBLE_EN defined:
  - Each framebuffer row is shown on two consecutive lines. Fetches occur only when next is even; displayed row = next>>1.
  - The base accumulator advances only on even fetches.
  - Odd-next triggers start no fetch and leave the banks unchanged, so the display re-reads the same bank.
- LINE_DOUBLE_EN undefined: one fetch per visible line as above.

Test Plan:
- Reset, run timing to vcount=749/hcount=1280 -> next 40 cycles: mem_addr_out 0..39 with mem_we_out=0; lb_we_out pulses with lb_addr_out 0..39, two cycles delayed; lb_rd_bank_out 0→1 after DRAIN.
- Continue to vcount=0/hcount=1280 -> mem_addr_out 40..79; lb_rd_bank_out toggles back to 0; no fetch at vcount=719 trigger.
- wr_req_in raised at vcount=5/hcount=1281 (during FETCH), addr=0x1234, data=0xDEADBEEF -> wr_gnt_out low for the remaining issue cycles and high in the first DRAIN cycle; the following cycle shows mem_we_out=1, mem_addr_out=0x1234, mem_wdata_out=0xDEADBEEF.
- wr_req_in high on a trigger cycle -> wr_gnt_out=0 that cycle; mem_addr_out shows a fetch address the next cycle.
- Reset pulsed at vcount=300 -> no fetches or bank toggles until vcount=749 trigger; the next fetch uses addresses 0..39; overrun_out stays 0.
- With LINE_DOUBLE_EN: triggers for next=0,1,2,3 -> fetch base addresses 0, none, 40, none; lb_rd_bank_out toggles twice.
